// File: rtl/bcd_display_scanner.sv
// ============================================================================
// Module   : bcd_display_scanner
// Purpose  : Latches packed BCD into a shadow register and time-multiplexes
//            the digits onto a shared 7-segment bus with per-digit enables.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024,
  parameter int DEADTIME   = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    slot_tick
);

  localparam int c_pw = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_iw = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_pw-1:0]       c_p_last  = c_pw'(SCAN_DIV - 1);
  localparam logic [c_iw-1:0]       c_i_last  = c_iw'(NUM_DIGITS - 1);
  localparam logic [6:0]            c_seg_pol = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] c_en_pol  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [c_pw-1:0]         r_p;
  logic [c_iw-1:0]         r_idx;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_slot_tick;

  logic [NUM_DIGITS-1:0]   w_keep;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [3:0]              w_cur_digit;
  logic                    w_cur_keep;
  logic                    w_dead;
  logic                    w_blank;
  logic                    w_slot_end;
  logic [6:0]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_en_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // A digit is kept visible when it or any more significant digit is non-zero.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_keep
    assign w_keep[k] = |r_shadow[4*NUM_DIGITS-1:4*k];
  end

  if (DEADTIME == 0) begin : g_no_dead
    assign w_dead = 1'b0;
  end else begin : g_dead
    assign w_dead = (r_p < c_pw'(DEADTIME));
  end

  always_comb begin
    w_cur_digit = 4'd0;
    w_cur_keep  = 1'b0;
    w_onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == c_iw'(k)) begin
        w_cur_digit = r_shadow[4*k +: 4];
        w_cur_keep  = w_keep[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  assign w_slot_end = (r_p == c_p_last);
  assign w_blank    = blank_lz & (r_idx != '0) & ~w_cur_keep;
  assign w_seg_next = (w_dead | w_blank) ? 7'h00 : decode(w_cur_digit);
  assign w_en_next  = w_dead ? '0 : w_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow    <= '0;
      r_p         <= '0;
      r_idx       <= '0;
      r_seg       <= c_seg_pol;
      r_digit_en  <= c_en_pol;
      r_slot_tick <= 1'b0;
    end else begin
      if (load) r_shadow <= bcd_in;
      if (w_slot_end) begin
        r_p   <= '0;
        r_idx <= (r_idx == c_i_last) ? '0 : r_idx + c_iw'(1);
      end else begin
        r_p   <= r_p + c_pw'(1);
      end
      r_seg       <= w_seg_next ^ c_seg_pol;
      r_digit_en  <= w_en_next ^ c_en_pol;
      r_slot_tick <= w_slot_end;
    end
  end

  assign seg       = r_seg;
  assign digit_en  = r_digit_en;
  assign slot_tick = r_slot_tick;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
// ============================================================================
// Module   : tb_bcd_display_scanner
// Purpose  : Self-checking bench for bcd_display_scanner (both pin polarities).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        blank_lz;
  logic [15:0] bcd_in;
  logic [6:0]  seg, seg_al;
  logic [3:0]  en, en_al;
  logic        tick, tick_al;

  int          checks   = 0;
  int          failures = 0;
  int          n        = 0;
  logic [15:0] m_shadow = '0;
  logic        m_active;
  int          m_idx;
  logic [6:0]  dec_tab [16];

  typedef struct packed {
    logic [15:0]     bcd;
    logic            blank;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEADTIME(DT), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
    .seg(seg), .digit_en(en), .slot_tick(tick)
  );

  bcd_display_scanner #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEADTIME(DT), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
    .seg(seg_al), .digit_en(en_al), .slot_tick(tick_al)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output seen after edge number e (0-based since reset release), from the shadow/blank_lz before it.
  function automatic void model_out(input int e, input logic [15:0] sh, input logic bl,
                                    output logic [6:0] s, output logic [3:0] de, output logic tk,
                                    output int di);
    int p;
    int d;
    p  = e % SD;
    di = (e / SD) % ND;
    tk = (p == SD - 1);
    s  = 7'h00;
    de = 4'h0;
    if (p >= DT) begin
      de = 4'(1 << di);
      d  = int'((sh >> (4 * di)) & 16'hF);
      if (bl && di > 0 && (sh >> (4 * di)) == 16'h0) s = 7'h00;
      else                                            s = dec_tab[d];
    end
  endfunction

  task automatic step();
    logic [6:0] es;
    logic [3:0] ee;
    logic       et;
    int         di;
    model_out(n, m_shadow, blank_lz, es, ee, et, di);
    m_active = (ee != 4'h0);
    m_idx    = di;
    @(posedge clk);
    #1;
    if (load) m_shadow = bcd_in;
    n++;
    check("outputs", {21'h0, et, ee, es}, {21'h0, tick, en, seg});
    check("outputs_al", {21'h0, et, ~ee, ~es}, {21'h0, tick_al, en_al, seg_al});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mask;
    logic        reached;
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    vecs[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'h0070, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3F}};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[3] = '{16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[4] = '{16'h00A5, 1'b0, {7'h3F, 7'h3F, 7'h40, 7'h6D}};
    vecs[5] = '{16'h00A5, 1'b1, {7'h00, 7'h00, 7'h40, 7'h6D}};
    vecs[6] = '{16'h0800, 1'b1, {7'h00, 7'h7F, 7'h3F, 7'h3F}};
    vecs[7] = '{16'h0008, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h7F}};

    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; bcd_in = '0;
    #2;
    check("reset_out", {20'h0, tick, en, seg}, 32'h0);
    check("reset_out_al", {20'h0, tick_al, en_al, seg_al}, {20'h0, 1'b0, 4'hF, 7'h7F});
    @(posedge clk); #1;
    check("reset_hold", {20'h0, tick, en, seg}, 32'h0);
    rst = 1'b0; n = 0; m_shadow = '0;

    repeat (2 * ND * SD) step();

    for (int i = 0; i < 8; i++) begin
      bcd_in = vecs[i].bcd; blank_lz = vecs[i].blank; load = 1'b1;
      step();
      load = 1'b0;
      repeat (ND * SD + 1) begin
        step();
        if (m_active) begin
          check("vec_seg", {25'h0, seg}, {25'h0, vecs[i].exp[m_idx]});
          check("vec_seg_al", {25'h0, seg_al}, {25'h0, ~vecs[i].exp[m_idx]});
        end
      end
    end

    // Async reset three enabled cycles into digit 2, with a non-zero shadow.
    bcd_in = 16'h1234; load = 1'b1; step(); load = 1'b0;
    reached = 1'b0;
    for (int g = 0; g < 2 * ND * SD && !reached; g++) begin
      step();
      reached = (m_idx == 2) && (((n - 1) % SD) == DT + 2);
    end
    check("reach_digit2", {31'h0, reached}, 32'h1);
    check("pre_reset_en", {28'h0, en}, 32'h4);
    #2; rst = 1'b1; #1;
    check("async_reset", {20'h0, tick, en, seg}, 32'h0);
    check("async_reset_al", {20'h0, tick_al, en_al, seg_al}, {20'h0, 1'b0, 4'hF, 7'h7F});
    @(posedge clk); #1;
    rst = 1'b0; n = 0; m_shadow = '0; blank_lz = 1'b0;
    repeat (DT + 1) step();
    check("restart_digit0", {21'h0, en, seg}, {21'h0, 4'b0001, 7'h3F});

    // Load on the slot-wrap edge shows at the next slot's first enabled cycle.
    while (n < 2 * SD - 1) step();
    bcd_in = 16'h0900; load = 1'b1;
    step();
    load = 1'b0;
    repeat (DT + 1) step();
    check("wrap_load", {21'h0, en, seg}, {21'h0, 4'b0100, 7'h6F});

    for (int r = 0; r < 600; r++) begin
      case ($urandom_range(3))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h00FF;
        2:       mask = 16'h000F;
        default: mask = 16'h0F00;
      endcase
      if ($urandom_range(7) == 0) begin
        bcd_in = 16'($urandom) & mask;
        load   = 1'b1;
      end else begin
        load   = 1'b0;
      end
      blank_lz = 1'($urandom_range(1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Multiplexed 7-segment display driver for the LED daughterboard. It takes the packed BCD outputs of cascaded decade counters, latches them into a shadow register on a load strobe (normally the top counter's carry or a sample tick), and time-multiplexes the digits onto a shared segment bus with per-digit enables. It is the consuming end of the counter cnt/carry interface.

Parameters:
NUM_DIGITS, 4, number of BCD digits / digit enable lines (1..8)
SCAN_DIV, 1024, clock cycles per digit slot (>= DEADTIME+1)
DEADTIME, 2, cycles at the start of each slot with all digits disabled (anti-ghosting, >= 0)
ACTIVE_LOW, 0, 1 = invert seg and digit_en at the pins (common-anode boards)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
bcd_in  input  4*NUM_DIGITS  packed BCD; digit k = bcd_in[4k+3:4k], k=0 least significant
load  input  1  capture bcd_in into shadow register on this clk edge
blank_lz  input  1  1 = blank leading zeros
seg  output  7  segments, seg[0]=a .. seg[6]=g
digit_en  output  NUM_DIGITS  one-hot digit enable, bit k drives digit k
slot_tick  output  1  1-cycle pulse on last cycle of each slot

Behaviour:
- Reset (async, any time incl. mid-scan): shadow=0, prescaler p=0, index idx=0, seg=all off, digit_en=all inactive, slot_tick=0 (pin levels honour ACTIVE_LOW). First rising edge after rst deasserts starts slot 0.
- Shadow: on clk edge with load=1, shadow<=bcd_in; otherwise hold. Display never reads bcd_in directly.
- Prescaler: p counts 0..SCAN_DIV-1 and wraps to 0. When p==SCAN_DIV-1, idx advances; NUM_DIGITS-1 wraps to 0.
- Outputs are registered and computed from current p, idx, shadow, blank_lz, so they have 1-cycle latency.
  - p<DEADTIME: digit_en all inactive, seg off.
  - Otherwise: digit_en one-hot at idx, seg=decode(shadow digit idx).
  - slot_tick registered from (p==SCAN_DIV-1).
- Each digit is enabled for exactly SCAN_DIV-DEADTIME consecutive cycles per frame. Frame = NUM_DIGITS*SCAN_DIV cycles.
- Decode, seg[6:0] active-high before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10..15 (invalid BCD) = 40 (dash only).
- Leading-zero blanking: when blank_lz=1, digit k is blanked (seg off, digit_en still asserted) if every digit j>=k in the shadow is 0. Digit 0 is never blanked; an all-zero shadow shows a single "0". A dash digit counts as non-zero.
- Load during a slot: seg may change mid-slot from the next registered cycle. No other effect on timing; p and idx are unaffected.
- blank_lz is sampled every cycle, with no latching.
- DEADTIME=0: no dead cycles; digit_en goes directly from one-hot k to one-hot k+1.
- ACTIVE_LOW=1: seg and digit_en are bitwise inverted at the output register. Reset then drives all ones.

Test Plan:
- Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, DEADTIME=2, ACTIVE_LOW=0.
- Reset then idle, load=0 → seg=00 and digit_en=0000 at reset. After deassert, slot_tick pulses every 8 cycles. Each of digit_en 0001, 0010, 0100, 1000 is high for 6 consecutive cycles, preceded by 2 cycles of 0000.
- load=1 with bcd_in=16'h1234, blank_lz=0 → seg=66 during digit_en=0001, 4F during 0010, 5B during 0100, 06 during 1000.
- bcd_in=16'h0070, blank_lz=1 → digits 3 and 2 have seg=00 with enable asserted; digit 1 shows 07, digit 0 shows 3F. Repeat with bcd_in=16'h0000 → only digit 0 shows 3F. With blank_lz=0 → all four digits show 3F.
- bcd_in=16'h00A5 → digit 1 shows 40 and digit 0 shows 6D. With blank_lz=1, digits 3 and 2 are blank.
- Assert rst asynchronously mid-slot, 3 cycles into digit 2 → seg and digit_en go inactive before the next clk edge and shadow reads 0. The scan restarts at digit 0 after release. A load asserted on the same edge as slot wrap is visible from the next slot's first enabled cycle.
- Rebuild with ACTIVE_LOW=1 and bcd_in=16'h0008 → during reset seg=7F and digit_en=1111. Digit 0 enabled gives seg=00 and digit_en=1110.
